// File: rtl/jtopl_pkg.sv
// Shared JTOPL envelope constants and the eg_shift width helper used by the timer and EG slots.
package jtopl_pkg;

  localparam int JTOPL_EG_CW_DEF  = 15;
  localparam int JTOPL_EG_DIV_DEF = 3;

  // Width needed to hold a trailing-zero count of 0..cw inclusive.
  function automatic int jtopl_eg_sw(input int cw);
    return $clog2(cw + 1);
  endfunction

endpackage

// File: rtl/jtopl_eg_ctz.sv
// Combinational trailing-zero counter; returns CW for an all-zero input.
module jtopl_eg_ctz #(
  parameter int CW = 15,
  parameter int SW = 4
) (
  input  logic [CW-1:0] i_val,
  output logic [SW-1:0] o_ctz
);

  // Scanning from the MSB down leaves the lowest set bit as the final winner.
  always_comb begin
    o_ctz = SW'(CW);
    for (int i = CW - 1; i >= 0; i--) begin
      if (i_val[i]) o_ctz = SW'(i);
    end
  end

endmodule

// File: rtl/jtopl_eg_timer.sv
// Global envelope timebase: prescales the sample strobe and advances the EG counter.
// Define JTOPL_EG_TIMER_TEST_EN to add the `test` port that bypasses the prescaler.
module jtopl_eg_timer
  import jtopl_pkg::*;
#(
  parameter int CW  = JTOPL_EG_CW_DEF,
  parameter int DIV = JTOPL_EG_DIV_DEF
) (
  input  logic                       rst,
  input  logic                       clk,
  input  logic                       cen,
  input  logic                       zero,
  input  logic                       clr,
  input  logic                       hold,
`ifdef JTOPL_EG_TIMER_TEST_EN
  input  logic                       test,
`endif
  output logic [CW-1:0]              eg_cnt,
  output logic                       eg_tick,
  output logic [jtopl_eg_sw(CW)-1:0] eg_shift
);

  localparam int SW = jtopl_eg_sw(CW);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] BaseLast = PW'(DIV - 1);

  logic [PW-1:0] r_base, w_base_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [SW-1:0] r_shift, w_shift_nxt;
  logic          r_tick, w_inc, w_adv;

  assign w_adv = cen & zero & ~clr & ~hold;

  always_comb begin
    w_base_nxt = r_base;
    w_cnt_nxt  = r_cnt;
    w_inc      = 1'b0;
    if (clr) begin
      w_base_nxt = '0;
      w_cnt_nxt  = '0;
`ifdef JTOPL_EG_TIMER_TEST_EN
    end else if (!hold && test) begin
      // Bypass keeps base parked at 0 so prescaling restarts cleanly when test drops.
      w_base_nxt = '0;
      if (w_adv) begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_inc     = 1'b1;
      end
`endif
    end else if (w_adv) begin
      if (r_base == BaseLast) begin
        w_base_nxt = '0;
        w_cnt_nxt  = r_cnt + 1'b1;
        w_inc      = 1'b1;
      end else begin
        w_base_nxt = r_base + 1'b1;
      end
    end
  end

  // Computed on the next count so eg_shift lines up with eg_cnt in the same cycle.
  jtopl_eg_ctz #(
    .CW (CW),
    .SW (SW)
  ) u_ctz (
    .i_val (w_cnt_nxt),
    .o_ctz (w_shift_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base  <= '0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_shift <= SW'(CW);
    end else if (cen) begin
      r_base  <= w_base_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tick  <= w_inc;
      r_shift <= w_shift_nxt;
    end
  end

  assign eg_cnt   = r_cnt;
  assign eg_tick  = r_tick;
  assign eg_shift = r_shift;

endmodule

// File: doc/jtopl_eg_timer.md
# jtopl_eg_timer

Parametrised global envelope timebase for the JTOPL envelope generator. It divides the sample-rate strobe by a configurable prescaler and advances a configurable-width envelope counter. Alongside the counter it publishes an increment pulse and a registered trailing-zero count of the counter, which per-operator EG rate logic uses to decide whether an attack or decay step fires. It sits between the timing/sequencer block (source of `zero`) and every EG slot.

## Interface
Parameters:
- `CW`, 15 — envelope counter width, 2..24.
- `DIV`, 3 — sample strobes per counter increment, 1..16. Prescaler width is `max(1,$clog2(DIV))`.

Ports:
- `rst`  in  1  reset, asynchronous, active-high.
- `clk`  in  1  clock.
- `cen`  in  1  clock enable. No state changes when low, except `rst`.
- `zero`  in  1  sample-boundary strobe, qualified by `cen`.
- `clr`  in  1  synchronous clear of prescaler and counter, qualified by `cen`.
- `hold`  in  1  freeze prescaler and counter, qualified by `cen`.
- `test`  in  1  bypass the prescaler. Present only with `JTOPL_EG_TIMER_TEST_EN`.
- `eg_cnt`  out  CW  envelope counter.
- `eg_tick`  out  1  high for one `cen` period after each counter increment.
- `eg_shift`  out  SW=$clog2(CW+1)  trailing zeros of `eg_cnt`; equals `CW` when `eg_cnt` is 0.

## Operation
- The event `adv` is `cen & zero & ~clr & ~hold`.
- Priority on each clock edge, highest first: `rst`, then `clr`, then `hold`, then `adv`.
- **Prescaler (`base`)**
  - On `adv`: if `base == DIV-1`, set `base` to 0 and increment `eg_cnt`; otherwise `base <= base+1`.
  - With `DIV==1`, every `adv` increments `eg_cnt`, and `base` stays 0.
- **Counter**
  - Modulo 2^CW; all-ones wraps to 0.
  - No saturation and no skip of 0.
- **`eg_tick`**
  - Set on the edge where `eg_cnt` increments.
  - Cleared on the next edge with `cen=1` where no increment occurs.
  - Back-to-back increments keep it high. This only happens with `DIV==1`, `test`, and a `zero` on consecutive `cen` cycles.
- **`eg_shift`**
  - Registered. Computed from the next value of `eg_cnt` so that it always matches `eg_cnt` in the same cycle.
  - Example: `eg_cnt` = 0x0008 gives `eg_shift` = 3.
- **`clr`**
  - On `cen`, sets `base`, `eg_cnt` and `eg_tick` to 0, and `eg_shift` to `CW`.
  - Overrides a coincident `zero`.
- **`hold`**
  - Blocks `adv`; `base` and `eg_cnt` keep their values.
  - `eg_tick` clears on the next `cen` edge.
- **`test` (macro builds only)**
  - `test=1`: every `adv` increments `eg_cnt`, and `base` is forced to 0.
  - Deasserting `test` restarts prescaling from `base=0`.
- **Reset values:** `base`=0, `eg_cnt`=0, `eg_tick`=0, `eg_shift`=`CW`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency is 0 extra cycles. `eg_cnt`, `eg_tick` and `eg_shift` all update on the edge that samples the qualifying `zero`.
- A `zero` with `cen=0` is ignored. The sequencer must hold `zero` until a `cen` cycle.
- Deasserting `rst` mid-frame: the first qualifying `zero` after reset moves `base` to 1 (for `DIV>1`).

## Configuration
- With `JTOPL_EG_TIMER_TEST_EN` defined:
  - the `test` port exists;
  - the prescaler bypass described under Operation is implemented.
- Without it:
  - there is no `test` port;
  - the behaviour is identical to a build with `test=0`;
  - no bypass mux is synthesised.

## Structure
- `jtopl_pkg` holds:
  - `JTOPL_EG_CW_DEF` (15);
  - `JTOPL_EG_DIV_DEF` (3);
  - the `eg_shift` width function `clog2(CW+1)`, shared with EG slot logic.
- Sub-module `jtopl_eg_ctz`: a purely combinational, parametrised trailing-zero counter of width `CW`. Its output is `CW` for an all-zero input. It is instanced once on the next-count value and reused by EG rate decode.

## Test plan
- **Reset:** assert `rst` during counting → `eg_cnt`=0, `base`=0, `eg_tick`=0, `eg_shift`=15 immediately, without waiting for a clock.
- **Prescale, DIV=3, CW=15:** 9 qualified `zero` strobes → `eg_cnt`=3; `eg_tick` pulses on strobes 3, 6 and 9; `eg_shift` reads 0, 1, 0 after those increments.
- **Wrap, CW=4, DIV=1:** 16 strobes from 0 → `eg_cnt` returns to 0 with `eg_shift`=4; at `eg_cnt`=8, `eg_shift`=3.
- **Priority:**
  - `clr` and `zero` together at `eg_cnt`=5, `base`=2 → `eg_cnt`=0, `base`=0, no tick.
  - `hold` for 4 strobes → `eg_cnt` unchanged.
- **`cen` gating:** `zero` asserted only while `cen=0` for 10 cycles → no state change. The same pulses with `cen=1` → normal advance.
- **Test mode (macro on), DIV=3:** `test=1` for 5 strobes → `eg_cnt`+=5. Drop `test`, then 3 strobes → `eg_cnt`+=1.
